// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: fetches a 16-bit instruction as two bytes (low at PC, high at PC+1), owns the PC; optional FETCH_TIMEOUT_EN wait timeout
module instruction_fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        FetchReq,
  input  logic        PCLoad,
  input  logic [15:0] PCIn,
  input  logic [7:0]  MemData,
  input  logic        MemReady,
  output logic        MemRead,
  output logic [15:0] MemAddr,
  output logic        IRWrite,
  output logic        IRLH,
  output logic [7:0]  IRData,
  output logic [15:0] PCOut,
  output logic        Busy,
  output logic        FetchDone,
  output logic        FetchErr
);
  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic ir_write_q, ir_write_d, ir_lh_q, ir_lh_d;
  logic [7:0] ir_data_q, ir_data_d;
  logic fetching, take;
  assign fetching = state_q == FETCH_LO || state_q == FETCH_HI;
  assign take = fetching && MemReady;
`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic [15:0] start_q, start_d;
  logic err_q, err_d, expire;
  assign expire = fetching && !MemReady && wait_q == 8'(TIMEOUT_CYCLES - 1);
`endif
  // next state, PC update and instruction-register byte capture
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_write_d = take;
    ir_lh_d = take ? state_q == FETCH_HI : ir_lh_q;
    ir_data_d = take ? MemData : ir_data_q;
    if (state_q == IDLE) begin
      pc_d = PCLoad ? PCIn : pc_q;
      state_d = FetchReq ? FETCH_LO : IDLE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (take) begin
      pc_d = pc_q + 16'd1;
      state_d = state_q == FETCH_LO ? FETCH_HI : DONE;
    end
`ifdef FETCH_TIMEOUT_EN
    start_d = state_q == IDLE ? pc_d : start_q;
    wait_d = state_d != state_q ? 8'd0 : (fetching && !MemReady) ? wait_q + 8'd1 : wait_q;
    err_d = expire;
    if (expire) begin
      state_d = IDLE;
      pc_d = start_q;
    end
`endif
  end
  // core state registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      ir_write_q <= 1'b0;
      ir_lh_q <= 1'b0;
      ir_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_write_q <= ir_write_d;
      ir_lh_q <= ir_lh_d;
      ir_data_q <= ir_data_d;
    end
  end
`ifdef FETCH_TIMEOUT_EN
  // wait counter, instruction start address and error pulse
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wait_q <= 8'd0;
      start_q <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      start_q <= start_d;
      err_q <= err_d;
    end
  end
  assign FetchErr = err_q;
`else
  assign FetchErr = TIMEOUT_CYCLES < 0;
`endif
  assign MemRead = fetching;
  assign MemAddr = pc_q;
  assign PCOut = pc_q;
  assign Busy = state_q != IDLE;
  assign FetchDone = state_q == DONE;
  assign IRWrite = ir_write_q;
  assign IRLH = ir_lh_q;
  assign IRData = ir_data_q;
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb_instruction_fetch_sequencer: randomized fetches against a byte-level reference model with a scoreboard monitor
module tb_instruction_fetch_sequencer;
  localparam logic [15:0] RST_PC = 16'h0100;
  logic clk = 1'b0;
  logic Reset, FetchReq, PCLoad, MemReady;
  logic [15:0] PCIn;
  logic [7:0] MemData;
  logic MemRead, IRWrite, IRLH, Busy, FetchDone, FetchErr;
  logic [15:0] MemAddr, PCOut;
  logic [7:0] IRData;
  logic rst_q = 1'b1;
  logic [8:0] exp_q[$];
  logic [8:0] last_ir = 9'h000;
  logic [8:0] e;
  logic [15:0] mpc;
  int n_checks = 0, n_pass = 0, done_cnt = 0, exp_done = 0;

  instruction_fetch_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(4)) dut (
    .Clock(clk), .Reset(Reset), .FetchReq(FetchReq), .PCLoad(PCLoad), .PCIn(PCIn),
    .MemData(MemData), .MemReady(MemReady), .MemRead(MemRead), .MemAddr(MemAddr),
    .IRWrite(IRWrite), .IRLH(IRLH), .IRData(IRData), .PCOut(PCOut), .Busy(Busy),
    .FetchDone(FetchDone), .FetchErr(FetchErr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign MemData = mem_byte(MemAddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) rst_q <= Reset;

  always @(negedge clk) begin
    if (rst_q) begin
      exp_q.delete();
      last_ir = 9'h000;
      check("rst_irwrite", 32'(IRWrite), 32'd0);
    end else begin
      check("fetch_err", 32'(FetchErr), 32'd0);
      if (IRWrite) begin
        if (exp_q.size() == 0) check("irwrite_spurious", 32'(IRWrite), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("ir_byte", 32'({IRLH, IRData}), 32'(e));
          last_ir = e;
        end
      end else check("ir_hold", 32'({IRLH, IRData}), 32'(last_ir));
      if (FetchDone) begin
        done_cnt++;
        check("done_with_hi", 32'({IRWrite, IRLH}), 32'b11);
      end
      if (MemRead) check("mem_addr", 32'(MemAddr), 32'(PCOut));
      if (!Busy) check("idle_no_read", 32'(MemRead), 32'd0);
    end
  end

  task automatic check_reset_outputs();
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_irlh", 32'(IRLH), 32'd0);
    check("rst_irdata", 32'(IRData), 32'd0);
    check("rst_pc", 32'(PCOut), 32'(RST_PC));
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(FetchDone), 32'd0);
    check("rst_err", 32'(FetchErr), 32'd0);
  endtask

  task automatic run_fetch(input logic ld, input logic [15:0] addr, input int rdy_pct);
    bit started = 0;
    bit fin = 0;
    @(posedge clk); #1;
    FetchReq = 1'b1;
    PCLoad = ld;
    PCIn = addr;
    MemReady = 1'($urandom_range(0, 1));
    if (ld) mpc = addr;
    exp_q.push_back({1'b0, mem_byte(mpc)});
    exp_q.push_back({1'b1, mem_byte(mpc + 16'd1)});
    mpc = mpc + 16'd2;
    exp_done++;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk); #1;
      if (Busy) begin
        started = 1;
        FetchReq = 1'($urandom_range(0, 1));
        PCLoad = 1'($urandom_range(0, 1));
        PCIn = ($urandom_range(0, 1) == 0) ? 16'h2000 : 16'($urandom);
        MemReady = $urandom_range(0, 99) < rdy_pct;
      end else fin = 1;
    end
    FetchReq = 1'b0;
    PCLoad = 1'b0;
    MemReady = 1'($urandom_range(0, 1));
    check("fetch_completes", 32'({started, fin}), 32'b11);
    @(negedge clk);
    check("pc_after", 32'(PCOut), 32'(mpc));
    check("idle_after", 32'(Busy), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    FetchReq = 1'b0;
    PCLoad = 1'b0;
    PCIn = 16'h0000;
    MemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_irwrite_init", 32'(IRWrite), 32'd0);
    check_reset_outputs();
    @(posedge clk); #1;
    Reset = 1'b0;
    mpc = RST_PC;
    run_fetch(1'b0, 16'h0000, 100);
    run_fetch(1'b1, 16'hFFFF, 100);
    run_fetch(1'b0, 16'h0000, 15);
    @(posedge clk); #1;
    FetchReq = 1'b1;
    MemReady = 1'b0;
    exp_q.push_back({1'b0, mem_byte(mpc)});
    exp_q.push_back({1'b1, mem_byte(mpc + 16'd1)});
    @(posedge clk); #1;
    FetchReq = 1'b0;
    MemReady = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_irwrite", 32'(IRWrite), 32'd0);
    check_reset_outputs();
    @(posedge clk); #1;
    Reset = 1'b0;
    MemReady = 1'b0;
    mpc = RST_PC;
    for (int i = 0; i < 40; i++) begin
      run_fetch(1'($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                int'($urandom_range(10, 100)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        MemReady = 1'($urandom_range(0, 1));
      end
    end
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(exp_done));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
